pid_ctrl_sat: RTL and testbench
===============================

Name: pid_ctrl_sat

Overview:
- Next-generation fixed-point PID controller for the control-loop modules.
- Adds runtime gains, a sample-valid handshake and a 3-stage pipeline.
- Adds an overflow-safe error path, integrator clamp (anti-windup) and optional first-order derivative smoothing.
- Adds output saturation with flags.
- Sits between a sensor/setpoint source and an actuator driver; one update per accepted sample.

Parameters:
- WIDTH, 16: signed width of setpoint, curpoint, output.
- QBITS, 8: fractional bits of gains (Q(GAIN_WIDTH-QBITS).QBITS).
- GAIN_WIDTH, 16: signed width of i_kp/i_ki/i_kd.
- ACC_WIDTH, 32: signed integrator width.
- I_LIMIT, 'h7FFF: integrator magnitude limit, must be >0 and <2^(ACC_WIDTH-1).
- D_SHIFT, 0: derivative smoothing shift. 0 = no filter; n gives alpha = 2^-n.

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: synchronous, active-high reset.
- i_valid, in, 1: sample strobe; one sample accepted per high cycle.
- i_setpoint, in, WIDTH: signed setpoint.
- i_curpoint, in, WIDTH: signed measurement.
- i_kp, in, GAIN_WIDTH: signed proportional gain, captured with sample.
- i_ki, in, GAIN_WIDTH: signed integral gain (per-sample, DT pre-folded), captured with sample.
- i_kd, in, GAIN_WIDTH: signed derivative gain (per-sample), captured with sample.
- i_clear, in, 1: clear integrator, derivative history and filter.
- o_valid, out, 1: o_out updated this cycle (1-cycle pulse per sample).
- o_out, out, WIDTH: signed saturated control output, held between updates.
- o_sat, out, 1: last o_out was clipped.
- o_i_sat, out, 1: integrator at ±I_LIMIT after last sample.

Behaviour:
- Reset (i_rst=1 at posedge) forces the following; takes priority over everything, including in-flight samples:
  - o_out=0, o_valid=0, o_sat=0, o_i_sat=0.
  - All stage valids 0; integrator=0, prev_error=0, d_filt=0, first=1.
- Latency: i_valid at edge N gives o_valid=1 and new o_out at edge N+3. Fully pipelined, so back-to-back samples give back-to-back results.
- S1 (on i_valid):
  - err = setpoint - curpoint, sign-extended to WIDTH+1 bits (no wrap).
  - d_raw = first ? 0 : err - prev_error, WIDTH+2 bits; no derivative kick on the first sample.
  - prev_error <= err; first <= 0.
  - integ <= clamp(integ + err, -I_LIMIT, +I_LIMIT); o_i_sat registered with it.
  - d_filt <= D_SHIFT==0 ? d_raw : d_filt + ((d_raw - d_filt) >>> D_SHIFT).
  - Gains and S1 results are registered into the S2 pipeline register.
- Internal state changes only on i_valid; idle cycles leave everything held.
- S2 (three signed products, registered):
  - P = err*kp.
  - I = integ_new*ki.
  - D = d_filt_new*kd.
- S3:
  - sum = P+I+D in width ACC_WIDTH+GAIN_WIDTH+2.
  - Then >>> QBITS (floor toward -inf).
  - Then clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - o_sat=1 iff clipped.
- i_clear with i_valid=0: clears integ, prev_error, d_filt, o_i_sat; sets first=1. In-flight samples complete with their captured values.
- i_clear with i_valid=1: the sample is processed as a first sample from cleared state (integ = clamp(err), d_raw=0).
- Gain changes affect only samples accepted after the change.
- Integrator never wraps; the clamp applies every sample.

Decomposition:
- Package pid_pkg:
  - localparams for intermediate widths (ERR_W=WIDTH+1, DER_W=WIDTH+2, SUM_W).
  - Function sat_signed(value, lo, hi) for saturation and flag.
- One sub-module, sat_clamp:
  - Parametrised IN_W/OUT_W; combinational clip plus clipped flag.
  - Instantiated for integrator and output.
- Derivative filter stays inline.

Test Plan (WIDTH=16, QBITS=8, GAIN_WIDTH=16, ACC_WIDTH=32):
- Latency/P: kp=0x100, ki=kd=0; setpoint=100, curpoint=0, one i_valid pulse -> o_valid exactly 3 cycles later, o_out=100, o_sat=0; o_out held afterwards.
- Integral and clamp:
  - I_LIMIT=1000, ki=0x080, kp=kd=0.
  - err=10 ×4 samples -> o_out 5,10,15,20.
  - Then i_clear; err=600 ×2 -> integ 600 then 1000; o_i_sat=0 then 1; o_out 300 then 500.
- Derivative, no kick: kd=0x100, kp=ki=0, D_SHIFT=0; err 50 then 80 -> o_out 0 then 30. With D_SHIFT=1, same inputs -> 0 then 15.
- Saturation and wide error:
  - kp=0x4000, setpoint=1000, curpoint=0 -> o_out=32767, o_sat=1.
  - kp=0x100, setpoint=-32768, curpoint=32767 -> err=-65535 (no wrap), o_out=-32768, o_sat=1.
- Back-to-back and gain capture: 4 consecutive i_valid with kp changed 0x100→0x200 at sample 3 -> 4 consecutive o_valid; samples 1-2 use 1.0, samples 3-4 use 2.0.
- Reset mid-flight: i_rst asserted 1 cycle after i_valid -> no o_valid; o_out=0; next sample behaves as first (d=0, integ=err).

Source files
------------

// File: rtl/pid_pkg.sv
// Shared width helpers and the signed saturation function used by the
// PID controller and its clamp sub-module.
package pid_pkg;

    typedef logic signed [127:0] wide_t;

    function automatic int err_w(input int width);
        return width + 1;
    endfunction

    function automatic int der_w(input int width);
        return width + 2;
    endfunction

    function automatic int sum_w(input int acc_width, input int gain_width);
        return acc_width + gain_width + 2;
    endfunction

    // Clip value into [lo, hi]; clipped reports whether the limit was applied.
    function automatic wide_t sat_signed(input wide_t value, input wide_t lo,
                                         input wide_t hi, output logic clipped);
        clipped = 1'b0;
        if (value > hi) begin
            clipped = 1'b1;
            return hi;
        end
        if (value < lo) begin
            clipped = 1'b1;
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/sat_clamp.sv
// Combinational signed clip from IN_W bits into [LO, HI] held in OUT_W bits,
// with a flag that is high whenever the input was outside the range.
module sat_clamp import pid_pkg::*; #(
    parameter int     IN_W  = 33,
    parameter int     OUT_W = 32,
    parameter longint LO    = -1,
    parameter longint HI    = 1
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clipped
);

    always_comb begin
        clipped = 1'b0;
        dout    = OUT_W'(sat_signed(wide_t'(din), wide_t'(LO), wide_t'(HI), clipped));
    end

endmodule

// File: rtl/pid_ctrl_sat.sv
// Three-stage fixed-point PID controller with runtime gains, integrator
// anti-windup clamp, optional derivative smoothing and saturated output.
module pid_ctrl_sat import pid_pkg::*; #(
    parameter int     WIDTH      = 16,
    parameter int     QBITS      = 8,
    parameter int     GAIN_WIDTH = 16,
    parameter int     ACC_WIDTH  = 32,
    parameter longint I_LIMIT    = 'h7FFF,
    parameter int     D_SHIFT    = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_valid,
    input  logic signed [WIDTH-1:0]      i_setpoint,
    input  logic signed [WIDTH-1:0]      i_curpoint,
    input  logic signed [GAIN_WIDTH-1:0] i_kp,
    input  logic signed [GAIN_WIDTH-1:0] i_ki,
    input  logic signed [GAIN_WIDTH-1:0] i_kd,
    input  logic                         i_clear,
    output logic                         o_valid,
    output logic signed [WIDTH-1:0]      o_out,
    output logic                         o_sat,
    output logic                         o_i_sat
);

    localparam int ERR_W = err_w(WIDTH);
    localparam int DER_W = der_w(WIDTH);
    localparam int SUM_W = sum_w(ACC_WIDTH, GAIN_WIDTH);
    localparam int P_W   = ERR_W + GAIN_WIDTH;
    localparam int I_W   = ACC_WIDTH + GAIN_WIDTH;
    localparam int D_W   = DER_W + GAIN_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] I_HI = ACC_WIDTH'(I_LIMIT);
    localparam logic signed [ACC_WIDTH-1:0] I_LO = -I_HI;

    // Handshake: i_valid high at a rising edge accepts exactly one sample (no
    // backpressure); o_valid is a one-cycle pulse three edges later.
    logic signed [ACC_WIDTH-1:0] integ, integ_base, integ_new;
    logic signed [ACC_WIDTH:0]   integ_sum;
    logic signed [ERR_W-1:0]     err, prev_error;
    logic signed [DER_W-1:0]     d_raw, d_filt, d_base, d_new;
    logic signed [DER_W:0]       d_diff;
    logic                        first, first_eff, integ_clip, i_sat_next;

    logic                        s1_valid, s2_valid, s3_valid;
    logic signed [ERR_W-1:0]     s1_err;
    logic signed [ACC_WIDTH-1:0] s1_integ;
    logic signed [DER_W-1:0]     s1_dfilt;
    logic signed [GAIN_WIDTH-1:0] s1_kp, s1_ki, s1_kd;
    logic signed [P_W-1:0]       s2_p;
    logic signed [I_W-1:0]       s2_i;
    logic signed [D_W-1:0]       s2_d;
    logic signed [SUM_W-1:0]     s3_sum, s3_shift;
    logic signed [WIDTH-1:0]     out_clamped;
    logic                        out_clip;

    // A clear arriving with a sample makes that sample start from cleared state.
    always_comb begin
        err        = $signed({i_setpoint[WIDTH-1], i_setpoint})
                   - $signed({i_curpoint[WIDTH-1], i_curpoint});
        first_eff  = first | i_clear;
        integ_base = i_clear ? '0 : integ;
        d_base     = i_clear ? '0 : d_filt;
        d_raw      = first_eff ? '0 : DER_W'(err) - DER_W'(prev_error);
        integ_sum  = (ACC_WIDTH+1)'(integ_base) + (ACC_WIDTH+1)'(err);
        d_diff     = '0;
        if (D_SHIFT == 0) begin
            d_new = d_raw;
        end else begin
            d_diff = (DER_W+1)'(d_raw) - (DER_W+1)'(d_base);
            d_new  = d_base + DER_W'(d_diff >>> D_SHIFT);
        end
        // Landing exactly on the rail counts as saturated, not only clipping.
        i_sat_next = integ_clip || (integ_new == I_HI) || (integ_new == I_LO);
        s3_shift   = s3_sum >>> QBITS;
    end

    sat_clamp #(
        .IN_W (ACC_WIDTH + 1),
        .OUT_W(ACC_WIDTH),
        .LO   (-I_LIMIT),
        .HI   (I_LIMIT)
    ) u_integ_clamp (
        .din    (integ_sum),
        .dout   (integ_new),
        .clipped(integ_clip)
    );

    sat_clamp #(
        .IN_W (SUM_W),
        .OUT_W(WIDTH),
        .LO   (-(64'sd1 <<< (WIDTH - 1))),
        .HI   ((64'sd1 <<< (WIDTH - 1)) - 64'sd1)
    ) u_out_clamp (
        .din    (s3_shift),
        .dout   (out_clamped),
        .clipped(out_clip)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            integ      <= '0;
            prev_error <= '0;
            d_filt     <= '0;
            first      <= 1'b1;
            o_i_sat    <= 1'b0;
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s3_valid   <= 1'b0;
            s1_err     <= '0;
            s1_integ   <= '0;
            s1_dfilt   <= '0;
            s1_kp      <= '0;
            s1_ki      <= '0;
            s1_kd      <= '0;
            s2_p       <= '0;
            s2_i       <= '0;
            s2_d       <= '0;
            s3_sum     <= '0;
            o_valid    <= 1'b0;
            o_out      <= '0;
            o_sat      <= 1'b0;
        end else begin
            if (i_valid) begin
                integ      <= integ_new;
                prev_error <= err;
                d_filt     <= d_new;
                first      <= 1'b0;
                o_i_sat    <= i_sat_next;
                s1_err     <= err;
                s1_integ   <= integ_new;
                s1_dfilt   <= d_new;
                s1_kp      <= i_kp;
                s1_ki      <= i_ki;
                s1_kd      <= i_kd;
            end else if (i_clear) begin
                integ      <= '0;
                prev_error <= '0;
                d_filt     <= '0;
                first      <= 1'b1;
                o_i_sat    <= 1'b0;
            end
            s1_valid <= i_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            o_valid  <= s3_valid;
            if (s1_valid) begin
                s2_p <= P_W'(s1_err) * P_W'(s1_kp);
                s2_i <= I_W'(s1_integ) * I_W'(s1_ki);
                s2_d <= D_W'(s1_dfilt) * D_W'(s1_kd);
            end
            if (s2_valid) begin
                s3_sum <= SUM_W'(s2_p) + SUM_W'(s2_i) + SUM_W'(s2_d);
            end
            if (s3_valid) begin
                o_out <= out_clamped;
                o_sat <= out_clip;
            end
        end
    end

endmodule

// File: tb/tb_pid_ctrl_sat.sv
// Bench for pid_ctrl_sat: two instances (I_LIMIT=1000/D_SHIFT=0 and
// I_LIMIT=0x7FFF/D_SHIFT=1) driven in parallel against a reference model.
module tb_pid_ctrl_sat;

    localparam int WIDTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic valid = 1'b0;
    logic clear = 1'b0;
    logic signed [15:0] sp = '0, cp = '0, kp = '0, ki = '0, kd = '0;

    logic o_valid0, o_sat0, o_isat0, o_valid1, o_sat1, o_isat1;
    logic signed [15:0] o_out0, o_out1;

    pid_ctrl_sat #(.WIDTH(16), .QBITS(8), .GAIN_WIDTH(16), .ACC_WIDTH(32),
                   .I_LIMIT(1000), .D_SHIFT(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_setpoint(sp), .i_curpoint(cp),
        .i_kp(kp), .i_ki(ki), .i_kd(kd), .i_clear(clear),
        .o_valid(o_valid0), .o_out(o_out0), .o_sat(o_sat0), .o_i_sat(o_isat0)
    );

    pid_ctrl_sat #(.WIDTH(16), .QBITS(8), .GAIN_WIDTH(16), .ACC_WIDTH(32),
                   .I_LIMIT('h7FFF), .D_SHIFT(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_setpoint(sp), .i_curpoint(cp),
        .i_kp(kp), .i_ki(ki), .i_kd(kd), .i_clear(clear),
        .o_valid(o_valid1), .o_out(o_out1), .o_sat(o_sat1), .o_i_sat(o_isat1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH:0] exp_q0[$];
    logic [WIDTH:0] exp_q1[$];
    logic [WIDTH:0] exp0, exp1;

    longint m_integ[2];
    longint m_prev[2];
    longint m_d[2];
    bit     m_first[2];
    longint m_lim[2] = '{1000, 32767};
    int     m_dsh[2] = '{0, 1};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_integ[k] = 0;
            m_prev[k]  = 0;
            m_d[k]     = 0;
            m_first[k] = 1;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_integ[k] = 0;
            m_prev[k]  = 0;
            m_d[k]     = 0;
            m_first[k] = 1;
        end
    endtask

    // Controller law in plain integer arithmetic; result queued per instance.
    task automatic model_step(input longint e, input longint gp, input longint gi,
                              input longint gd, input bit clr);
        for (int k = 0; k < 2; k++) begin
            longint draw, total, y;
            bit s;
            if (clr) begin
                m_integ[k] = 0;
                m_d[k]     = 0;
                m_first[k] = 1;
            end
            draw = m_first[k] ? 0 : e - m_prev[k];
            m_prev[k]  = e;
            m_first[k] = 0;
            m_integ[k] = m_integ[k] + e;
            if (m_integ[k] > m_lim[k]) m_integ[k] = m_lim[k];
            if (m_integ[k] < -m_lim[k]) m_integ[k] = -m_lim[k];
            if (m_dsh[k] == 0) m_d[k] = draw;
            else m_d[k] = m_d[k] + ((draw - m_d[k]) >>> m_dsh[k]);
            total = e * gp + m_integ[k] * gi + m_d[k] * gd;
            y = total >>> 8;
            s = 0;
            if (y > 32767) begin y = 32767; s = 1; end
            if (y < -32768) begin y = -32768; s = 1; end
            if (k == 0) exp_q0.push_back({s, y[15:0]});
            else exp_q1.push_back({s, y[15:0]});
        end
    endtask

    task automatic send(input logic signed [15:0] s, input logic signed [15:0] c,
                        input logic signed [15:0] p, input logic signed [15:0] i,
                        input logic signed [15:0] d, input bit clr);
        sp = s; cp = c; kp = p; ki = i; kd = d; clear = clr; valid = 1'b1;
        model_step(longint'(s) - longint'(c), longint'(p), longint'(i), longint'(d), clr);
        @(posedge clk); #1;
        valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic clear_idle();
        clear = 1'b1;
        model_clear();
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic wait_result();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every o_valid pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (o_valid0 === 1'b1) begin
            n_tests++;
            if (exp_q0.size() == 0) begin
                n_fail++;
                $display("FAIL sb0_unexpected got out=%0d sat=%0b, none expected", o_out0, o_sat0);
            end else begin
                exp0 = exp_q0.pop_front();
                if ({o_sat0, o_out0} !== exp0) begin
                    n_fail++;
                    $display("FAIL sb0 got out=%0d sat=%0b expected out=%0d sat=%0b",
                             o_out0, o_sat0, $signed(exp0[15:0]), exp0[16]);
                end
            end
        end
        if (o_valid1 === 1'b1) begin
            n_tests++;
            if (exp_q1.size() == 0) begin
                n_fail++;
                $display("FAIL sb1_unexpected got out=%0d sat=%0b, none expected", o_out1, o_sat1);
            end else begin
                exp1 = exp_q1.pop_front();
                if ({o_sat1, o_out1} !== exp1) begin
                    n_fail++;
                    $display("FAIL sb1 got out=%0d sat=%0b expected out=%0d sat=%0b",
                             o_out1, o_sat1, $signed(exp1[15:0]), exp1[16]);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({o_valid0, o_sat0, o_isat0, o_out0} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_dut0 got v=%b sat=%b isat=%b out=%0d expected all 0",
                     o_valid0, o_sat0, o_isat0, o_out0);
        end
        n_tests++;
        if ({o_valid1, o_sat1, o_isat1, o_out1} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_dut1 got v=%b sat=%b isat=%b out=%0d expected all 0",
                     o_valid1, o_sat1, o_isat1, o_out1);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_latency();
        send(16'sd100, 16'sd0, 16'sh0100, 16'sd0, 16'sd0, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            n_tests++;
            if (o_valid0 !== (c == 3)) begin
                n_fail++;
                $display("FAIL latency_edge%0d got o_valid=%b expected %b", c, o_valid0, (c == 3));
            end
        end
        n_tests++;
        if (o_out0 !== 16'sd100 || o_sat0 !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_value got out=%0d sat=%b expected 100 0", o_out0, o_sat0);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (o_valid0 !== 1'b0 || o_out0 !== 16'sd100) begin
            n_fail++;
            $display("FAIL latency_hold got v=%b out=%0d expected 0 100", o_valid0, o_out0);
        end
    endtask

    task automatic test_integral();
        for (int k = 1; k <= 4; k++) begin
            send(16'sd10, 16'sd0, 16'sd0, 16'sh0080, 16'sd0, k == 1);
            wait_result();
            n_tests++;
            if (o_valid0 !== 1'b1 || o_out0 !== 16'(5 * k)) begin
                n_fail++;
                $display("FAIL integ_step%0d got v=%b out=%0d expected 1 %0d", k, o_valid0, o_out0, 5 * k);
            end
        end
        clear_idle();
        send(16'sd600, 16'sd0, 16'sd0, 16'sh0080, 16'sd0, 1'b0);
        wait_result();
        n_tests++;
        if (o_out0 !== 16'sd300 || o_isat0 !== 1'b0) begin
            n_fail++;
            $display("FAIL integ_600 got out=%0d isat=%b expected 300 0", o_out0, o_isat0);
        end
        send(16'sd600, 16'sd0, 16'sd0, 16'sh0080, 16'sd0, 1'b0);
        wait_result();
        n_tests++;
        if (o_out0 !== 16'sd500 || o_isat0 !== 1'b1) begin
            n_fail++;
            $display("FAIL integ_clamp got out=%0d isat=%b expected 500 1", o_out0, o_isat0);
        end
    endtask

    task automatic test_derivative();
        send(16'sd50, 16'sd0, 16'sd0, 16'sd0, 16'sh0100, 1'b1);
        wait_result();
        n_tests++;
        if (o_out0 !== 16'sd0 || o_out1 !== 16'sd0) begin
            n_fail++;
            $display("FAIL deriv_nokick got out0=%0d out1=%0d expected 0 0", o_out0, o_out1);
        end
        send(16'sd80, 16'sd0, 16'sd0, 16'sd0, 16'sh0100, 1'b0);
        wait_result();
        n_tests++;
        if (o_out0 !== 16'sd30 || o_out1 !== 16'sd15) begin
            n_fail++;
            $display("FAIL deriv_step got out0=%0d out1=%0d expected 30 15", o_out0, o_out1);
        end
    endtask

    task automatic test_saturation();
        send(16'sd1000, 16'sd0, 16'sh4000, 16'sd0, 16'sd0, 1'b1);
        wait_result();
        n_tests++;
        if (o_out0 !== 16'sh7FFF || o_sat0 !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_pos got out=%0d sat=%b expected 32767 1", o_out0, o_sat0);
        end
        send(16'sh8000, 16'sh7FFF, 16'sh0100, 16'sd0, 16'sd0, 1'b1);
        wait_result();
        n_tests++;
        if (o_out1 !== 16'sh8000 || o_sat1 !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_neg_wide got out=%0d sat=%b expected -32768 1", o_out1, o_sat1);
        end
    endtask

    task automatic test_back_to_back();
        int exp_b2b[4] = '{10, 20, 60, 80};
        send(16'sd10, 16'sd0, 16'sh0100, 16'sd0, 16'sd0, 1'b1);
        send(16'sd20, 16'sd0, 16'sh0100, 16'sd0, 16'sd0, 1'b0);
        send(16'sd30, 16'sd0, 16'sh0200, 16'sd0, 16'sd0, 1'b0);
        send(16'sd40, 16'sd0, 16'sh0200, 16'sd0, 16'sd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (o_valid0 !== 1'b1 || o_out0 !== 16'(exp_b2b[i])) begin
                n_fail++;
                $display("FAIL b2b_%0d got v=%b out=%0d expected 1 %0d", i, o_valid0, o_out0, exp_b2b[i]);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (o_valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end got o_valid=%b expected 0", o_valid0);
        end
    endtask

    task automatic test_reset_midflight();
        repeat (6) @(posedge clk);
        #1;
        send(16'sd40, 16'sd0, 16'sh0100, 16'sh0100, 16'sh0100, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if (o_valid0 !== 1'b0 || o_valid1 !== 1'b0 || o_out0 !== 16'sd0) begin
                n_fail++;
                $display("FAIL rst_flight_c%0d got v0=%b v1=%b out0=%0d expected 0 0 0",
                         c, o_valid0, o_valid1, o_out0);
            end
            @(posedge clk); #1;
        end
        send(16'sd25, 16'sd0, 16'sd0, 16'sh0100, 16'sh0100, 1'b0);
        wait_result();
        n_tests++;
        if (o_out0 !== 16'sd25 || o_out1 !== 16'sd25) begin
            n_fail++;
            $display("FAIL rst_first_sample got out0=%0d out1=%0d expected 25 25", o_out0, o_out1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            int sel;
            logic signed [15:0] rs, rc, rp, ri, rd;
            sel = int'($urandom_range(0, 19));
            rs = 16'($urandom);
            rc = 16'($urandom);
            rp = (sel < 10) ? 16'($urandom) : 16'($signed(10'($urandom)));
            ri = (sel % 2 == 0) ? 16'($urandom) : 16'($signed(9'($urandom)));
            rd = 16'($urandom);
            if (sel < 3) begin
                @(posedge clk); #1;
            end else if (sel == 3) begin
                clear_idle();
            end else begin
                send(rs, rc, rp, ri, rd, sel == 4);
            end
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_drain();
        n_tests++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain got pending0=%0d pending1=%0d expected 0 0",
                     exp_q0.size(), exp_q1.size());
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_latency();
        test_integral();
        test_derivative();
        test_saturation();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        test_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
